// File: rtl/load_store_unit.sv
// RV32I load/store unit: byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW mapped onto a word-addressed memory.
// Sub-word support (lane extract, read-modify-write) is built only when LSU_SUBWORD_EN is defined.
module load_store_unit #(
  parameter int MEM_WORDS = 256
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        iReq,
  input  logic        iWrite,
  input  logic [2:0]  iFunct3,
  input  logic [31:0] iAddress,
  input  logic [31:0] iData,
  output logic [31:0] oData,
  output logic        oDone,
  output logic        oBusy,
  output logic        oFault,
  output logic        oMemRead,
  output logic        oMemWrite,
  output logic [31:0] oMemAddress,
  output logic [31:0] oMemData,
  input  logic [31:0] iMemData
);

  localparam logic [31:0] ADDR_LIMIT = 32'(MEM_WORDS * 4);

`ifdef LSU_SUBWORD_EN
  localparam int ALO = 0;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RMW_READ, S_WRITE, S_DONE} state_t;
`else
  // Word-only build: legal accesses are aligned, so the low address bits carry nothing.
  localparam int ALO = 2;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WRITE, S_DONE} state_t;
`endif

  state_t          state_q, state_d;
  logic [31:ALO]   addr_q, addr_d;
  logic            fault_q, fault_d;
  logic [31:0]     merge_q, merge_d;
  logic [31:0]     data_q, data_d;
`ifdef LSU_SUBWORD_EN
  logic [2:0]      funct3_q, funct3_d;
  logic [15:0]     wdata_q, wdata_d;
`endif

  function automatic logic access_fault(input logic wr, input logic [2:0] f3,
                                        input logic [31:0] a);
    logic illegal, misalign;
`ifdef LSU_SUBWORD_EN
    illegal  = (f3 == 3'b011) || (f3[2:1] == 2'b11) || (f3[2] && wr);
    misalign = ((f3[1:0] == 2'b01) && a[0]) || ((f3 == 3'b010) && (a[1:0] != 2'b00));
`else
    illegal  = (f3 != 3'b010) || (wr && 1'b0);
    misalign = (a[1:0] != 2'b00);
`endif
    return illegal || misalign || (a >= ADDR_LIMIT);
  endfunction

`ifdef LSU_SUBWORD_EN
  function automatic logic [31:0] lane_extract(input logic [31:0] word, input logic [2:0] f3,
                                               input logic [1:0] a);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{a, 3'b000} +: 8];
    h = a[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'h0, b};
      3'b101:  r = {16'h0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] word, input logic [2:0] f3,
                                             input logic [1:0] a, input logic [15:0] d);
    logic [31:0] r;
    r = word;
    if (f3[0] == 1'b0) r[{a, 3'b000} +: 8] = d[7:0];
    else if (a[1])     r[31:16] = d;
    else               r[15:0]  = d;
    return r;
  endfunction
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    fault_d = fault_q;
    merge_d = merge_q;
    data_d  = data_q;
`ifdef LSU_SUBWORD_EN
    funct3_d = funct3_q;
    wdata_d  = wdata_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (iReq) begin
          addr_d  = iAddress[31:ALO];
          fault_d = access_fault(iWrite, iFunct3, iAddress);
`ifdef LSU_SUBWORD_EN
          funct3_d = iFunct3;
          wdata_d  = iData[15:0];
`endif
          if (fault_d) begin
            // Result is cleared on entry so it is already 0 while oDone is high.
            data_d  = 32'h0;
            state_d = S_DONE;
          end else if (!iWrite) begin
            state_d = S_LOAD;
`ifdef LSU_SUBWORD_EN
          end else if (iFunct3 != 3'b010) begin
            state_d = S_RMW_READ;
`endif
          end else begin
            merge_d = iData;
            state_d = S_WRITE;
          end
        end
      end
      S_LOAD: begin
`ifdef LSU_SUBWORD_EN
        data_d = lane_extract(iMemData, funct3_q, addr_q[1:0]);
`else
        data_d = iMemData;
`endif
        state_d = S_DONE;
      end
`ifdef LSU_SUBWORD_EN
      S_RMW_READ: begin
        merge_d = lane_merge(iMemData, funct3_q, addr_q[1:0], wdata_q);
        state_d = S_WRITE;
      end
`endif
      S_WRITE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      fault_q  <= 1'b0;
      merge_q  <= 32'h0;
      data_q   <= 32'h0;
`ifdef LSU_SUBWORD_EN
      funct3_q <= 3'b000;
      wdata_q  <= 16'h0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      fault_q  <= fault_d;
      merge_q  <= merge_d;
      data_q   <= data_d;
`ifdef LSU_SUBWORD_EN
      funct3_q <= funct3_d;
      wdata_q  <= wdata_d;
`endif
    end
  end

  // Strobes decode straight from state so an asynchronous reset removes them at once.
  assign oBusy       = (state_q != S_IDLE);
  assign oDone       = (state_q == S_DONE);
  assign oFault      = oDone && fault_q;
`ifdef LSU_SUBWORD_EN
  assign oMemRead    = (state_q == S_LOAD) || (state_q == S_RMW_READ);
`else
  assign oMemRead    = (state_q == S_LOAD);
`endif
  assign oMemWrite   = (state_q == S_WRITE);
  assign oMemAddress = {addr_q[31:2], 2'b00};
  assign oMemData    = merge_q;
  assign oData       = data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a behavioural model predicts each access, the result is
// compared when oDone arrives. Expectations follow LSU_SUBWORD_EN the same way the design does.
module tb_load_store_unit;

`ifdef LSU_SUBWORD_EN
  localparam bit SUB = 1'b1;
`else
  localparam bit SUB = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n;
  logic        iReq, iWrite;
  logic [2:0]  iFunct3;
  logic [31:0] iAddress, iData, iMemData;
  logic [31:0] oData, oMemAddress, oMemData;
  logic        oDone, oBusy, oFault, oMemRead, oMemWrite;

  load_store_unit #(.MEM_WORDS(256)) dut (
    .clock(clock), .reset_n(reset_n), .iReq(iReq), .iWrite(iWrite), .iFunct3(iFunct3),
    .iAddress(iAddress), .iData(iData), .oData(oData), .oDone(oDone), .oBusy(oBusy),
    .oFault(oFault), .oMemRead(oMemRead), .oMemWrite(oMemWrite), .oMemAddress(oMemAddress),
    .oMemData(oMemData), .iMemData(iMemData)
  );

  always #5 clock = ~clock;

  logic [31:0] mem [256] = '{default: 32'h0};
  logic [31:0] ref_mem [256] = '{default: 32'h0};
  assign iMemData = mem[oMemAddress[9:2]];
  always @(posedge clock) if (oMemWrite) mem[oMemAddress[9:2]] <= oMemData;

  int rd_total = 0, wr_total = 0, both_total = 0;
  logic [31:0] last_wa = 32'h0, last_wd = 32'h0;
  always @(negedge clock) begin
    if (oMemRead) rd_total <= rd_total + 1;
    if (oMemWrite) begin
      wr_total <= wr_total + 1;
      last_wa  <= oMemAddress;
      last_wd  <= oMemData;
    end
    if (oMemRead && oMemWrite) both_total <= both_total + 1;
  end

  typedef struct {
    logic [31:0] data;
    logic        fault;
    int          lat;
    int          rd;
    int          wr;
    logic [31:0] wa;
    logic [31:0] wdata;
  } exp_t;
  exp_t sb[$];

  int checks = 0, errors = 0;
  logic [31:0] last_data = 32'h0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit model_fault(input bit wr, input logic [2:0] f3, input logic [31:0] a);
    bit legal, aligned;
    if (SUB) legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) ||
                     (!wr && ((f3 == 3'd4) || (f3 == 3'd5)));
    else     legal = (f3 == 3'd2);
    case (f3)
      3'd1, 3'd5: aligned = (a[0] == 1'b0);
      3'd2:       aligned = (a[1:0] == 2'b00);
      default:    aligned = 1'b1;
    endcase
    return !legal || !aligned || (a >= 32'd1024);
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [2:0] f3,
                                             input logic [1:0] k);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'((w >> (8 * k)) & 32'hFF);
    h = 16'((w >> (16 * k[1])) & 32'hFFFF);
    case (f3)
      3'd0:    return {{24{b[7]}}, b};
      3'd1:    return {{16{h[15]}}, h};
      3'd4:    return {24'h0, b};
      3'd5:    return {16'h0, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] w, input logic [2:0] f3,
                                              input logic [1:0] k, input logic [31:0] d);
    logic [31:0] mask;
    if (f3 == 3'd2) return d;
    if (f3 == 3'd0) begin
      mask = 32'hFF << (8 * k);
      return (w & ~mask) | ((d & 32'hFF) << (8 * k));
    end
    mask = 32'hFFFF << (16 * k[1]);
    return (w & ~mask) | ((d & 32'hFFFF) << (16 * k[1]));
  endfunction

  task automatic wait_idle();
    for (int i = 0; i < 8 && oBusy; i++) @(negedge clock);
  endtask

  task automatic issue(input string tag, input bit wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    int lat, rd0, wr0;
    logic [31:0] w;
    e.fault = model_fault(wr, f3, a);
    w = ref_mem[a[9:2]];
    e.wa = {a[31:2], 2'b00};
    e.wdata = 32'h0;
    if (e.fault) begin
      e.lat = 1; e.data = 32'h0; e.rd = 0; e.wr = 0;
    end else if (!wr) begin
      e.lat = 2; e.data = model_load(w, f3, a[1:0]); e.rd = 1; e.wr = 0;
    end else begin
      e.wdata = model_store(w, f3, a[1:0], d);
      e.lat = (f3 == 3'd2) ? 2 : 3;
      e.rd  = (f3 == 3'd2) ? 0 : 1;
      e.wr  = 1;
      e.data = last_data;
      ref_mem[a[9:2]] = e.wdata;
    end
    last_data = e.data;
    sb.push_back(e);

    wait_idle();
    rd0 = rd_total; wr0 = wr_total;
    iReq = 1'b1; iWrite = wr; iFunct3 = f3; iAddress = a; iData = d;
    @(posedge clock);
    #1;
    // Scramble the request inputs so only the latched copies can produce the result.
    iReq = 1'b0; iAddress = $urandom; iData = $urandom; iFunct3 = 3'($urandom); iWrite = 1'($urandom);
    lat = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      lat++;
      if (lat == 1) check({tag, "_busy"}, 32'(oBusy), 32'd1);
      if (oDone) break;
    end
    #1;
    e = sb.pop_front();
    check({tag, "_done"}, 32'(oDone), 32'd1);
    check({tag, "_lat"}, 32'(lat), 32'(e.lat));
    check({tag, "_fault"}, 32'(oFault), 32'(e.fault));
    check({tag, "_data"}, oData, e.data);
    check({tag, "_rd"}, 32'(rd_total - rd0), 32'(e.rd));
    check({tag, "_wr"}, 32'(wr_total - wr0), 32'(e.wr));
    if (e.wr != 0) begin
      check({tag, "_waddr"}, last_wa, e.wa);
      check({tag, "_wdata"}, last_wd, e.wdata);
    end
  endtask

  logic [2:0] f3_tab [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  initial begin
    logic [2:0] rf3;
    reset_n = 1'b0; iReq = 1'b0; iWrite = 1'b0; iFunct3 = 3'd0; iAddress = 32'h0; iData = 32'h0;
    repeat (2) @(negedge clock);
    #1;
    check("rst_data", oData, 32'h0);
    check("rst_done", 32'(oDone), 32'd0);
    check("rst_busy", 32'(oBusy), 32'd0);
    check("rst_fault", 32'(oFault), 32'd0);
    check("rst_rd", 32'(oMemRead), 32'd0);
    check("rst_wr", 32'(oMemWrite), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    issue("sw4",    1'b1, 3'd2, 32'h004, 32'h8899AABB);
    issue("lb6",    1'b0, 3'd0, 32'h006, 32'h0);
    issue("lbu6",   1'b0, 3'd4, 32'h006, 32'h0);
    issue("sb5",    1'b1, 3'd0, 32'h005, 32'h00000012);
    issue("lw4",    1'b0, 3'd2, 32'h004, 32'h0);
    issue("sh6",    1'b1, 3'd1, 32'h006, 32'h0000CAFE);
    issue("lhu6",   1'b0, 3'd5, 32'h006, 32'h0);
    issue("lh6",    1'b0, 3'd1, 32'h006, 32'h0);
    issue("lh4",    1'b0, 3'd1, 32'h004, 32'h0);
    issue("lb7",    1'b0, 3'd0, 32'h007, 32'h0);
    issue("lw_mis", 1'b0, 3'd2, 32'h002, 32'h0);
    issue("sw_oor", 1'b1, 3'd2, 32'h400, 32'h11111111);
    issue("lh_odd", 1'b0, 3'd1, 32'h001, 32'h0);
    issue("f011",   1'b0, 3'd3, 32'h000, 32'h0);
    issue("sbu",    1'b1, 3'd4, 32'h000, 32'h0);
    issue("f110",   1'b0, 3'd6, 32'h000, 32'h0);
    issue("sw_top", 1'b1, 3'd2, 32'h3FC, 32'h12345678);
    issue("lw_top", 1'b0, 3'd2, 32'h3FC, 32'h0);
    issue("sh_top", 1'b1, 3'd1, 32'h3FE, 32'h0000BEEF);
    issue("lw_top2",1'b0, 3'd2, 32'h3FC, 32'h0);
    issue("lw_oor", 1'b0, 3'd2, 32'hFFFF_FFFC, 32'h0);

    for (int i = 0; i < 40; i++) begin
      rf3 = f3_tab[$urandom_range(0, 4)];
      issue("rnd", 1'($urandom), rf3, 32'($urandom_range(0, 63)), $urandom);
    end

    // Abort a store in its write cycle: the strobe must vanish and memory must keep its word.
    wait_idle();
    iReq = 1'b1; iWrite = 1'b1; iFunct3 = SUB ? 3'd0 : 3'd2; iAddress = 32'h008; iData = 32'h5A5A5A5A;
    @(posedge clock);
    #1 iReq = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (oMemWrite) break;
    end
    check("abort_wr_seen", 32'(oMemWrite), 32'd1);
    reset_n = 1'b0;
    #1;
    check("abort_wr_drop", 32'(oMemWrite), 32'd0);
    check("abort_rd", 32'(oMemRead), 32'd0);
    check("abort_busy", 32'(oBusy), 32'd0);
    check("abort_done", 32'(oDone), 32'd0);
    check("abort_data", oData, 32'h0);
    @(posedge clock);
    @(negedge clock);
    check("abort_done2", 32'(oDone), 32'd0);
    check("abort_mem", mem[2], ref_mem[2]);
    reset_n = 1'b1;
    last_data = 32'h0;
    issue("lw_after", 1'b0, 3'd2, 32'h008, 32'h0);
    issue("lw_after4", 1'b0, 3'd2, 32'h004, 32'h0);

    for (int i = 0; i < 256; i++) check("mem_final", mem[i], ref_mem[i]);
    check("strobe_excl", 32'(both_total), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Load/store unit between the core's execute stage and the word-addressed data memory. It takes byte-addressed RV32I loads and stores (LB/LH/LW/LBU/LHU, SB/SH/SW) and turns them into whole-word memory reads and writes. Sub-word stores are done as a read-modify-write sequence, and sub-word loads are sign- or zero-extended. It detects faults and stalls the core with a busy/done handshake.

## Interface
- MEM_WORDS, 256, memory depth in 32-bit words; byte addresses ≥ MEM_WORDS*4 fault.
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- iReq  in  1  access request; sampled only in IDLE.
- iWrite  in  1  1 = store, 0 = load.
- iFunct3  in  3  RV32I width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU for loads only).
- iAddress  in  32  byte address.
- iData  in  32  store data (rs2).
- oData  out  32  extended load result (registered).
- oDone  out  1  one-cycle completion pulse.
- oBusy  out  1  high whenever state ≠ IDLE.
- oFault  out  1  valid with oDone; the access was rejected.
- oMemRead  out  1  memory read strobe.
- oMemWrite  out  1  memory write strobe.
- oMemAddress  out  32  word-aligned byte address, {addr[31:2],2'b00}.
- oMemData  out  32  word to write.
- iMemData  in  32  memory read data, valid combinationally in the same cycle as oMemRead.

## Operation
- **Request capture.** In IDLE with iReq=1, latch iWrite, iFunct3, iAddress and iData, then classify the access:
  - **Fault:** illegal funct3 (011, 11x, or 1xx with iWrite=1), misalignment (H with addr[0]≠0, W with addr[1:0]≠0), or addr ≥ MEM_WORDS*4. Go to DONE with the fault flag set.
  - **Load:** go to LOAD.
  - **SW:** go to WRITE with the merge register = iData.
  - **SB/SH:** go to RMW_READ.
- **LOAD.** Assert oMemRead. Capture and extend iMemData:
  - B/BU: byte lane addr[1:0].
  - H/HU: half lane addr[1].
  - Sign-extend for B/H, zero-extend for BU/HU.
  - Write the result to oData. Go to DONE.
- **RMW_READ.** Assert oMemRead. Load the merge register with iMemData, with the addressed lane replaced:
  - SB: bits [8k+7:8k] ← iData[7:0], where k = addr[1:0].
  - SH: bits [16h+15:16h] ← iData[15:0], where h = addr[1].
  - Go to WRITE.
- **WRITE.** Assert oMemWrite with oMemData = merge register. Go to DONE.
- **DONE.** oDone=1. oFault = fault flag. On a fault, oData ← 0. Go to IDLE.
- **Data hold.** oData holds its value across stores until the next load or fault completes.
- **Strobe exclusivity.** oMemRead and oMemWrite are never high together. Both are decoded combinationally from the state.
- **Core handshake.** The core must drop iReq, or present the next access, in the oDone cycle. A high iReq in IDLE starts a new access.

## Timing
- **Reset** (asynchronous, immediate): state = IDLE; oData, the merge register and the latches = 0; oDone, oFault, oBusy, oMemRead and oMemWrite = 0.
- **Reset mid-operation:** strobes drop immediately. An aborted RMW never writes. No oDone is issued.
- **Latency**, as cycles from the iReq sample edge to oDone:
  - Load: 2.
  - SW: 2.
  - SB/SH: 3.
  - Fault: 1.
- **Back-to-back:** the minimum gap between oDone and the next iReq acceptance is 0 cycles. IDLE follows DONE.
- **oMemAddress** is driven from the latched address in every non-IDLE state.

## Configuration
- **LSU_SUBWORD_EN**
  - **Defined:** full behaviour as above.
  - **Undefined:**
    - Only LW and SW are legal; every other funct3 faults.
    - RMW_READ and the lane extract/merge logic are removed.
    - Latencies for LW, SW and faults are unchanged.

## Test plan
- SW 0x8899AABB to 0x004 -> one oMemWrite cycle with addr 0x004 and data 0x8899AABB. oDone follows 2 cycles after the request edge. oFault=0.
- LB from 0x006, then LBU from 0x006 (word 0x8899AABB) -> oData 0xFFFFFF99, then 0x00000099.
- SB 0x12 to 0x005, then LW from 0x004 -> one read cycle, then one write of 0x889912BB. oDone at cycle 3. The LW returns 0x889912BB.
- SH 0xCAFE to 0x006, then LHU from 0x006 -> word 0xCAFE12BB; oData 0x0000CAFE.
- LW at 0x002, then SW at 0x400 (MEM_WORDS=256) -> oDone and oFault on the cycle after each request edge, no memory strobes, oData=0.
- Reset asserted during the WRITE state of an SB -> oMemWrite drops at once, no oDone, memory unchanged. After release, the next LW completes normally.
